conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Job sequencer between axi_csr and the convolution datapath. On a start edge it validates the
//  CSR geometry, then walks output pixels in raster order (co, oy, ox) and issues one command per
//  pixel over a valid/ready channel, tracking outstanding completions. Drives running,
//  compute_done and exception back into axi_csr.
// PARAMETERS
//  DATA_WIDTH       32  width of CSR address/size fields
//  ELEM_BYTES       4   bytes per output element and per kernel weight
//  MAX_OUTSTANDING  4   maximum issued-but-uncompleted commands (>=1)
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   asynchronous active-low reset
//  start            in   1   CSR start bit (level); rising edge launches a job
//  kernel_size      in   8   K (square kernel)
//  stride           in   8   S
//  padding          in   8   P
//  has_bias         in   1   copied into every command
//  has_relu         in   1   copied into every command
//  kernel_baseaddr  in   32  weight base byte address
//  output_baseaddr  in   32  output base byte address
//  feature_width    in   32  FW
//  feature_height   in   32  FH
//  feature_chin     in   32  CI
//  feature_chout    in   32  CO
//  output_width     in   32  OW programmed by software
//  output_height    in   32  OH programmed by software
//  running          out  1   job in progress
//  compute_done     out  1   sticky, job completed
//  exception        out  1   sticky, job rejected or protocol error
//  cmd_valid        out  1   command valid
//  cmd_ready        in   1   datapath accepts command
//  cmd_ox/oy/co     out  16  output pixel coordinates
//  cmd_ix/cmd_iy    out  17  signed input window origin: ox*S-P, oy*S-P
//  cmd_kaddr        out  32  kernel_baseaddr + co*K*K*CI*ELEM_BYTES
//  cmd_oaddr        out  32  output_baseaddr + ((co*OH+oy)*OW+ox)*ELEM_BYTES
//  cmd_bias/relu    out  1   has_bias / has_relu sampled at start
//  cmd_last         out  1   final command of the job
//  rsp_done         in   1   single-cycle pulse, one per completed command
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, outstanding count 0, start-edge register 0.
//  FSM: IDLE -> CHECK (start 0->1 seen) -> ISSUE -> DRAIN -> DONE -> IDLE; CHECK -> ERROR -> IDLE.
//  IDLE: start edge samples all config inputs into internal regs, clears compute_done and exception.
//  CHECK: exactly 2 cycles; running=1. Reject (-> ERROR) if K==0, S==0, CO==0, FW+2P<K, FH+2P<K,
//    OW != (FW+2P-K)/S+1, or OH != (FH+2P-K)/S+1 (unsigned, floor division). Also computes the
//    kernel step K*K*CI*ELEM_BYTES (mod 2^32).
//  ISSUE: cmd_valid=1 while outstanding < MAX_OUTSTANDING; payload stable while valid && !ready.
//    On handshake, advance ox; at OW-1 wrap to 0 and advance oy; at OH-1 wrap to 0 and advance co.
//    cmd_ix/iy/kaddr/oaddr are updated by accumulators, with no per-pixel multiply: oaddr += ELEM_BYTES.
//    The handshake on the command with cmd_last=1 -> DRAIN.
//  Outstanding count: +1 on cmd handshake, -1 on rsp_done; both in one cycle -> unchanged.
//  rsp_done with count 0 (and no handshake that cycle): set exception, do not decrement, continue.
//  DRAIN: running=1, cmd_valid=0; count==0 -> DONE.
//  DONE: one cycle; compute_done<=1, running<=0 -> IDLE.
//  ERROR: one cycle; exception<=1, running<=0, no command issued -> IDLE.
//  running=1 in CHECK/ISSUE/DRAIN only. Start edges outside IDLE are ignored. start held high
//    causes no relaunch; a 0->1 transition is required.
//  Reset mid-job: async return to IDLE; outputs cleared immediately; late rsp_done after reset in
//    IDLE with count 0 sets exception (documented, software must quiesce the datapath).
// TESTING
//  FW=FH=4,K=3,S=1,P=0,OW=OH=2,CO=2,CI=1, cmd_ready=1 -> 8 cmds, oaddr base+0..28 step 4,
//    kaddr base / base+36, cmd_last on 8th only; done after 8 rsp_done.
//  FW=5,K=3,S=2,P=1,OW=OH=3,CO=1 -> cmd_ix sequence -1,1,3 per row; cmd_iy -1,1,3 per row group.
//  OW programmed 3 for the first case -> exception=1 after CHECK, zero cmd_valid, running low.
//  rsp_done withheld, MAX_OUTSTANDING=4 -> exactly 4 handshakes then cmd_valid=0 until a rsp_done.
//  Random cmd_ready stalls -> payload constant during stall, no skipped/duplicated pixel.
//  rst_n low during ISSUE -> all outputs 0 immediately; new start edge runs the job cleanly.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Convolution job sequencer: validates CSR geometry, then issues one command per output
// pixel in (co, oy, ox) raster order with a bounded number of outstanding completions.
module conv_seq_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int ELEM_BYTES      = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            kernel_size,
   input  logic [7:0]            stride,
   input  logic [7:0]            padding,
   input  logic                  has_bias,
   input  logic                  has_relu,
   input  logic [DATA_WIDTH-1:0] kernel_baseaddr,
   input  logic [DATA_WIDTH-1:0] output_baseaddr,
   input  logic [DATA_WIDTH-1:0] feature_width,
   input  logic [DATA_WIDTH-1:0] feature_height,
   input  logic [DATA_WIDTH-1:0] feature_chin,
   input  logic [DATA_WIDTH-1:0] feature_chout,
   input  logic [DATA_WIDTH-1:0] output_width,
   input  logic [DATA_WIDTH-1:0] output_height,
   output logic                  running,
   output logic                  compute_done,
   output logic                  exception,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [15:0]           cmd_ox,
   output logic [15:0]           cmd_oy,
   output logic [15:0]           cmd_co,
   output logic [16:0]           cmd_ix,
   output logic [16:0]           cmd_iy,
   output logic [DATA_WIDTH-1:0] cmd_kaddr,
   output logic [DATA_WIDTH-1:0] cmd_oaddr,
   output logic                  cmd_bias,
   output logic                  cmd_relu,
   output logic                  cmd_last,
   input  logic                  rsp_done
);

   localparam int                    CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, DONE, ERROR} state_t;
   state_t state;

   logic                  start_q, chk_ph;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [7:0]            k_r, s_r, p_r;
   logic                  bias_r, relu_r;
   logic [DATA_WIDTH-1:0] kbase_r, obase_r, fw_r, fh_r, ci_r, co_r, ow_r, oh_r;
   logic [DATA_WIDTH:0]   w_span, h_span, ow_exp, oh_exp, k_ext, s_ext;
   logic [15:0]           kk;
   logic [DATA_WIDTH-1:0] kstep;
   logic                  start_edge, hs, spurious, cfg_bad;
   logic                  ox_wrap, oy_wrap, nxt_last;
   logic [15:0]           nxt_ox, nxt_oy, nxt_co;
   logic signed [16:0]    neg_pad;

   always_comb begin
      start_edge = start & ~start_q;
      hs         = cmd_valid & cmd_ready;
      spurious   = rsp_done & ~hs & (cnt == '0);
      cnt_nxt    = cnt;
      if (hs && !rsp_done)
         cnt_nxt = cnt + CNT_W'(1);
      else if (!hs && rsp_done && cnt != '0)
         cnt_nxt = cnt - CNT_W'(1);

      // A zero stride is rejected anyway; divide by 1 so the quotient stays defined.
      k_ext   = (DATA_WIDTH+1)'(k_r);
      s_ext   = (s_r == 8'd0) ? (DATA_WIDTH+1)'(1) : (DATA_WIDTH+1)'(s_r);
      ow_exp  = (w_span - k_ext) / s_ext + (DATA_WIDTH+1)'(1);
      oh_exp  = (h_span - k_ext) / s_ext + (DATA_WIDTH+1)'(1);
      cfg_bad = (k_r == 8'd0) || (s_r == 8'd0) || (co_r == '0) ||
                (w_span < k_ext) || (h_span < k_ext) ||
                (ow_exp != {1'b0, ow_r}) || (oh_exp != {1'b0, oh_r});
      neg_pad = -$signed({9'd0, p_r});

      ox_wrap  = (DATA_WIDTH'(cmd_ox) == ow_r - ONE);
      oy_wrap  = (DATA_WIDTH'(cmd_oy) == oh_r - ONE);
      nxt_ox   = ox_wrap ? 16'd0 : cmd_ox + 16'd1;
      nxt_oy   = ox_wrap ? (oy_wrap ? 16'd0 : cmd_oy + 16'd1) : cmd_oy;
      nxt_co   = (ox_wrap && oy_wrap) ? cmd_co + 16'd1 : cmd_co;
      nxt_last = (DATA_WIDTH'(nxt_ox) == ow_r - ONE) && (DATA_WIDTH'(nxt_oy) == oh_r - ONE) &&
                 (DATA_WIDTH'(nxt_co) == co_r - ONE);
   end

   // Job configuration and derived geometry: data only, no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && start_edge) begin
         k_r     <= kernel_size;
         s_r     <= stride;
         p_r     <= padding;
         bias_r  <= has_bias;
         relu_r  <= has_relu;
         kbase_r <= kernel_baseaddr;
         obase_r <= output_baseaddr;
         fw_r    <= feature_width;
         fh_r    <= feature_height;
         ci_r    <= feature_chin;
         co_r    <= feature_chout;
         ow_r    <= output_width;
         oh_r    <= output_height;
      end
      if (state == CHECK && !chk_ph) begin
         w_span <= {1'b0, fw_r} + (DATA_WIDTH+1)'({p_r, 1'b0});
         h_span <= {1'b0, fh_r} + (DATA_WIDTH+1)'({p_r, 1'b0});
         kk     <= 16'(k_r) * 16'(k_r);
      end
      if (state == CHECK && chk_ph)
         kstep <= DATA_WIDTH'(kk) * ci_r * DATA_WIDTH'(ELEM_BYTES);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         start_q      <= 1'b0;
         chk_ph       <= 1'b0;
         cnt          <= '0;
         running      <= 1'b0;
         compute_done <= 1'b0;
         exception    <= 1'b0;
         cmd_valid    <= 1'b0;
         cmd_ox       <= '0;
         cmd_oy       <= '0;
         cmd_co       <= '0;
         cmd_ix       <= '0;
         cmd_iy       <= '0;
         cmd_kaddr    <= '0;
         cmd_oaddr    <= '0;
         cmd_bias     <= 1'b0;
         cmd_relu     <= 1'b0;
         cmd_last     <= 1'b0;
      end else begin
         start_q <= start;
         cnt     <= cnt_nxt;
         if (spurious)
            exception <= 1'b1;
         case (state)
            IDLE: if (start_edge) begin
               state        <= CHECK;
               chk_ph       <= 1'b0;
               running      <= 1'b1;
               compute_done <= 1'b0;
               exception    <= 1'b0;
            end
            CHECK: if (!chk_ph) begin
               chk_ph <= 1'b1;
            end else if (cfg_bad) begin
               state     <= ERROR;
               running   <= 1'b0;
               exception <= 1'b1;
            end else begin
               state     <= ISSUE;
               cmd_valid <= (cnt_nxt < MAX_CNT);
               cmd_ox    <= '0;
               cmd_oy    <= '0;
               cmd_co    <= '0;
               cmd_ix    <= neg_pad;
               cmd_iy    <= neg_pad;
               cmd_kaddr <= kbase_r;
               cmd_oaddr <= obase_r;
               cmd_bias  <= bias_r;
               cmd_relu  <= relu_r;
               cmd_last  <= (co_r == ONE) && (oh_r == ONE) && (ow_r == ONE);
            end
            ISSUE: begin
               cmd_valid <= !(hs && cmd_last) && (cnt_nxt < MAX_CNT);
               if (hs) begin
                  cmd_ox    <= nxt_ox;
                  cmd_oy    <= nxt_oy;
                  cmd_co    <= nxt_co;
                  cmd_ix    <= ox_wrap ? neg_pad : cmd_ix + {9'd0, s_r};
                  cmd_iy    <= !ox_wrap ? cmd_iy : (oy_wrap ? neg_pad : cmd_iy + {9'd0, s_r});
                  cmd_kaddr <= (ox_wrap && oy_wrap) ? cmd_kaddr + kstep : cmd_kaddr;
                  cmd_oaddr <= cmd_oaddr + DATA_WIDTH'(ELEM_BYTES);
                  cmd_last  <= nxt_last;
                  if (cmd_last)
                     state <= DRAIN;
               end
            end
            DRAIN: if (cnt == '0) begin
               state        <= DONE;
               running      <= 1'b0;
               compute_done <= 1'b1;
            end
            DONE:    state <= IDLE;
            ERROR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: geometry walk, rejection, outstanding limit, stalls, reset.
module tb_conv_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, has_bias, has_relu, cmd_ready, rsp_done;
   logic [7:0]  kernel_size, stride, padding;
   logic [31:0] kernel_baseaddr, output_baseaddr, feature_width, feature_height;
   logic [31:0] feature_chin, feature_chout, output_width, output_height;
   logic        running, compute_done, exception, cmd_valid, cmd_bias, cmd_relu, cmd_last;
   logic [15:0] cmd_ox, cmd_oy, cmd_co;
   logic [16:0] cmd_ix, cmd_iy;
   logic [31:0] cmd_kaddr, cmd_oaddr;

   int checks = 0;
   int failures = 0;
   int pending = 0;
   int stall_bad, stalls;
   logic [15:0] r_ox[64], r_oy[64], r_co[64];
   logic [16:0] r_ix[64], r_iy[64];
   logic [31:0] r_ka[64], r_oa[64];
   logic        r_last[64], r_bias[64], r_relu[64];

   wire [148:0] payload = {cmd_ox, cmd_oy, cmd_co, cmd_ix, cmd_iy, cmd_kaddr, cmd_oaddr,
                           cmd_last, cmd_bias, cmd_relu};

   always #5 clk = ~clk;

   conv_seq_ctrl #(.DATA_WIDTH(32), .ELEM_BYTES(4), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .kernel_size(kernel_size), .stride(stride), .padding(padding),
      .has_bias(has_bias), .has_relu(has_relu),
      .kernel_baseaddr(kernel_baseaddr), .output_baseaddr(output_baseaddr),
      .feature_width(feature_width), .feature_height(feature_height),
      .feature_chin(feature_chin), .feature_chout(feature_chout),
      .output_width(output_width), .output_height(output_height),
      .running(running), .compute_done(compute_done), .exception(exception),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ox(cmd_ox), .cmd_oy(cmd_oy), .cmd_co(cmd_co), .cmd_ix(cmd_ix), .cmd_iy(cmd_iy),
      .cmd_kaddr(cmd_kaddr), .cmd_oaddr(cmd_oaddr), .cmd_bias(cmd_bias), .cmd_relu(cmd_relu),
      .cmd_last(cmd_last), .rsp_done(rsp_done)
   );

   task automatic set_cfg(input int fw, input int fh, input int k, input int s, input int p,
                          input int ci, input int co, input int ow, input int oh);
      feature_width  = 32'(fw);
      feature_height = 32'(fh);
      kernel_size    = 8'(k);
      stride         = 8'(s);
      padding        = 8'(p);
      feature_chin   = 32'(ci);
      feature_chout  = 32'(co);
      output_width   = 32'(ow);
      output_height  = 32'(oh);
      kernel_baseaddr = 32'h1000;
      output_baseaddr = 32'h8000;
      has_bias = 1'b1;
      has_relu = 1'b0;
   endtask

   task automatic launch();
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk);
   endtask

   // Drives cmd_ready (mode 0: always, mode 1: stalling) and answers every handshake with
   // one rsp_done a cycle or more later; records accepted commands until done or exception.
   task automatic run_job(input int mode, input int budget, output int n, output int ended);
      logic [148:0] held;
      bit held_v;
      n = 0; ended = 0; held_v = 0; held = '0; stall_bad = 0; stalls = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (compute_done) begin ended = 1; break; end
         if (exception) begin ended = 2; break; end
         if (pending > 0) begin rsp_done = 1'b1; pending--; end
         else rsp_done = 1'b0;
         cmd_ready = (mode == 0) ? 1'b1 : ((c % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
         if (held_v && held !== payload) stall_bad++;
         if (cmd_valid && cmd_ready) begin
            if (n < 64) begin
               r_ox[n] = cmd_ox; r_oy[n] = cmd_oy; r_co[n] = cmd_co;
               r_ix[n] = cmd_ix; r_iy[n] = cmd_iy; r_ka[n] = cmd_kaddr; r_oa[n] = cmd_oaddr;
               r_last[n] = cmd_last; r_bias[n] = cmd_bias; r_relu[n] = cmd_relu;
            end
            n++; pending++; held_v = 0;
         end else if (cmd_valid) begin
            held_v = 1; held = payload; stalls++;
         end else held_v = 0;
      end
      rsp_done = 1'b0;
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b0; rsp_done = 1'b0;
      set_cfg(4, 4, 3, 1, 0, 1, 2, 2, 2);
      repeat (3) @(negedge clk);
      checks++;
      if ({running, compute_done, exception, cmd_valid, cmd_last} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {running, compute_done, exception, cmd_valid, cmd_last});
      end
      checks++;
      if (payload !== '0) begin
         failures++; $display("FAIL reset_payload: got %h expected 0", payload);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int n, ended;
      logic [112:0] got, exp;
      set_cfg(4, 4, 3, 1, 0, 1, 2, 2, 2);
      launch();
      checks++;
      if (running !== 1'b1) begin failures++; $display("FAIL basic_running: got %b expected 1", running); end
      pending = 0;
      run_job(0, 200, n, ended);
      checks++;
      if (ended !== 1) begin failures++; $display("FAIL basic_end: got %0d expected 1", ended); end
      checks++;
      if (n !== 8) begin failures++; $display("FAIL basic_count: got %0d expected 8", n); end
      for (int i = 0; i < 8 && i < n; i++) begin
         got = {r_ox[i], r_oy[i], r_co[i], r_oa[i], r_ka[i], r_last[i]};
         exp = {16'(i % 2), 16'((i / 2) % 2), 16'(i / 4), 32'h8000 + 32'(4 * i),
                32'h1000 + ((i >= 4) ? 32'd36 : 32'd0), 1'(i == 7)};
         checks++;
         if (got !== exp) begin failures++; $display("FAIL basic_cmd[%0d]: got %h expected %h", i, got, exp); end
      end
      checks++;
      if ({r_bias[0], r_relu[0]} !== 2'b10) begin
         failures++; $display("FAIL basic_flags: got %b expected 10", {r_bias[0], r_relu[0]});
      end
      repeat (5) @(negedge clk);
      checks++;
      if ({running, cmd_valid, compute_done, exception} !== 4'b0010) begin
         failures++;
         $display("FAIL basic_after: got %b expected 0010", {running, cmd_valid, compute_done, exception});
      end
   endtask

   task automatic test_stride();
      int n, ended;
      logic [66:0] got, exp;
      set_cfg(5, 5, 3, 2, 1, 1, 1, 3, 3);
      launch();
      run_job(0, 200, n, ended);
      checks++;
      if (ended !== 1 || n !== 9) begin
         failures++; $display("FAIL stride_end: got end=%0d n=%0d expected end=1 n=9", ended, n);
      end
      for (int i = 0; i < 9 && i < n; i++) begin
         got = {r_ix[i], r_iy[i], r_oa[i], r_last[i]};
         exp = {17'(-1 + 2 * (i % 3)), 17'(-1 + 2 * (i / 3)), 32'h8000 + 32'(4 * i), 1'(i == 8)};
         checks++;
         if (got !== exp) begin failures++; $display("FAIL stride_cmd[%0d]: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_reject();
      int rk[5]  = '{3, 0, 3, 3, 5};
      int rs[5]  = '{1, 1, 0, 1, 1};
      int rco[5] = '{2, 2, 2, 0, 2};
      int row[5] = '{3, 2, 2, 2, 2};
      int nv;
      cmd_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         set_cfg(4, 4, rk[t], rs[t], 0, 1, rco[t], row[t], 2);
         launch();
         checks++;
         if (running !== 1'b1) begin failures++; $display("FAIL reject_check[%0d]: running %b expected 1", t, running); end
         nv = 0;
         repeat (6) begin @(negedge clk); if (cmd_valid) nv++; end
         checks++;
         if (nv !== 0 || {exception, running, compute_done} !== 3'b100) begin
            failures++;
            $display("FAIL reject[%0d]: valid_cycles=%0d exc/run/done=%b expected 0 and 100",
                     t, nv, {exception, running, compute_done});
         end
      end
      cmd_ready = 1'b0;
   endtask

   task automatic test_outstanding();
      int hs, nv, n, ended;
      set_cfg(4, 4, 3, 1, 0, 1, 2, 2, 2);
      launch();
      cmd_ready = 1'b1; rsp_done = 1'b0; hs = 0; nv = 0;
      repeat (12) begin @(negedge clk); if (cmd_valid && cmd_ready) hs++; end
      checks++;
      if (hs !== 4) begin failures++; $display("FAIL outst_hs: got %0d expected 4", hs); end
      repeat (10) begin @(negedge clk); if (cmd_valid) nv++; end
      checks++;
      if (nv !== 0) begin failures++; $display("FAIL outst_blocked: valid cycles %0d expected 0", nv); end
      rsp_done = 1'b1;
      pending = 3;
      run_job(0, 200, n, ended);
      checks++;
      if (ended !== 1 || n !== 4) begin
         failures++; $display("FAIL outst_end: got end=%0d n=%0d expected end=1 n=4", ended, n);
      end
      checks++;
      if ({r_oa[0], r_last[3]} !== {32'h8010, 1'b1}) begin
         failures++; $display("FAIL outst_resume: got %h/%b expected 8010/1", r_oa[0], r_last[3]);
      end
   endtask

   task automatic test_stall();
      int n, ended;
      logic [111:0] got, exp;
      set_cfg(5, 5, 3, 2, 1, 1, 2, 3, 3);
      launch();
      run_job(1, 800, n, ended);
      checks++;
      if (ended !== 1 || n !== 18) begin
         failures++; $display("FAIL stall_end: got end=%0d n=%0d expected end=1 n=18", ended, n);
      end
      checks++;
      if (stall_bad !== 0 || stalls == 0) begin
         failures++; $display("FAIL stall_hold: changed=%0d stalls=%0d expected 0 and >0", stall_bad, stalls);
      end
      for (int i = 0; i < 18 && i < n; i++) begin
         got = {r_ox[i], r_oy[i], r_co[i], r_oa[i], r_ka[i]};
         exp = {16'(i % 3), 16'((i / 3) % 3), 16'(i / 9), 32'h8000 + 32'(4 * i),
                32'h1000 + ((i >= 9) ? 32'd36 : 32'd0)};
         checks++;
         if (got !== exp) begin failures++; $display("FAIL stall_cmd[%0d]: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_spurious();
      int n, ended;
      start = 1'b0;
      @(negedge clk); rsp_done = 1'b1;
      @(negedge clk); rsp_done = 1'b0;
      checks++;
      if ({exception, running} !== 2'b10) begin
         failures++; $display("FAIL spurious_exc: got %b expected 10", {exception, running});
      end
      set_cfg(4, 4, 3, 1, 0, 1, 2, 2, 2);
      launch();
      checks++;
      if (exception !== 1'b0) begin failures++; $display("FAIL spurious_clear: got %b expected 0", exception); end
      pending = 0;
      run_job(0, 200, n, ended);
      checks++;
      if (ended !== 1 || n !== 8) begin
         failures++; $display("FAIL spurious_job: got end=%0d n=%0d expected end=1 n=8", ended, n);
      end
   endtask

   task automatic test_reset_mid();
      int n, ended;
      set_cfg(4, 4, 3, 1, 0, 1, 2, 2, 2);
      launch();
      cmd_ready = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({running, cmd_valid, compute_done, exception} !== 4'b0 || payload !== '0) begin
         failures++;
         $display("FAIL midreset_out: got %b/%h expected 0000/0",
                  {running, cmd_valid, compute_done, exception}, payload);
      end
      start = 1'b0; cmd_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      launch();
      pending = 0;
      run_job(0, 200, n, ended);
      checks++;
      if (ended !== 1 || n !== 8 || exception !== 1'b0) begin
         failures++;
         $display("FAIL midreset_job: got end=%0d n=%0d exc=%b expected 1/8/0", ended, n, exception);
      end
      checks++;
      if (r_oa[0] !== 32'h8000) begin failures++; $display("FAIL midreset_first: got %h expected 8000", r_oa[0]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stride();
      test_reject();
      test_outstanding();
      test_stall();
      test_spurious();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
